// File: rtl/transmit_cgrundey_pkg.sv
// Shared types and constants for the transmit frame builder.
package transmit_cgrundey_pkg;

    localparam int unsigned BIN_W        = 6;
    localparam int unsigned FRAME_W      = 12;
    localparam int unsigned MAX_VAL      = 39;
    localparam int unsigned SHIFT_CYCLES = 6;
    localparam int unsigned CNT_W        = 3;
    localparam int unsigned TENS_W       = 3;
    localparam int unsigned TENS_FRAME_W = 2;
    localparam int unsigned UNITS_W      = 4;
    localparam int unsigned WORK_W       = TENS_W + UNITS_W + BIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Double-dabble working vector, shifted left as one unit.
    typedef struct packed {
        logic [TENS_W-1:0]  tens;
        logic [UNITS_W-1:0] units;
        logic [BIN_W-1:0]   bin;
    } work_t;

    // Outgoing frame payload.
    typedef struct packed {
        logic [BIN_W-1:0]        bin;
        logic [TENS_FRAME_W-1:0] tens;
        logic [UNITS_W-1:0]      units;
    } frame_t;

    function automatic logic in_range(input logic [BIN_W-1:0] v);
        return v <= BIN_W'(MAX_VAL);
    endfunction

endpackage

// File: rtl/transmit_cgrundey_if.sv
// Upstream value handshake and downstream frame handshake of the transmit frame builder.
// err_inject exists only when TX_ERR_INJECT_EN is defined.
interface transmit_cgrundey_if;
    import transmit_cgrundey_pkg::*;

    logic [BIN_W-1:0]   data_in;
    logic               data_valid;
    logic               data_ready;
    logic [FRAME_W-1:0] frame_out;
    logic               frame_valid;
    logic               frame_ack;
    logic               range_err;
`ifdef TX_ERR_INJECT_EN
    logic               err_inject;
`endif

    modport master (
`ifdef TX_ERR_INJECT_EN
        output err_inject,
`endif
        output data_in, data_valid, frame_ack,
        input  data_ready, frame_out, frame_valid, range_err
    );

    modport slave (
`ifdef TX_ERR_INJECT_EN
        input  err_inject,
`endif
        input  data_in, data_valid, frame_ack,
        output data_ready, frame_out, frame_valid, range_err
    );

endinterface

// File: rtl/transmit_cgrundey_dabble_step.sv
// One double-dabble iteration: add-3 correction on units, then one-bit left shift.
module dabble_step_cgrundey
    import transmit_cgrundey_pkg::*;
(
    input  work_t work,
    output work_t work_next_c
);

    work_t corr;

    always_comb begin
        corr = work;
        if (work.units >= UNITS_W'(5)) begin
            corr.units = work.units + UNITS_W'(3);
        end
        work_next_c = {corr[WORK_W-2:0], 1'b0};
        // Tens MSB is sticky; it never sets for in-range inputs.
        work_next_c.tens[TENS_W-1] = corr.tens[TENS_W-1] | corr.tens[TENS_W-2];
    end

endmodule

// File: rtl/transmit_cgrundey.sv
// Transmit frame builder: binary 0..39 -> {binary, BCD} frame via a 6-cycle double-dabble.
// Build macro TX_ERR_INJECT_EN adds err_inject, which flips frame bit 6 of the tagged frame.
module transmit_cgrundey
    import transmit_cgrundey_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    transmit_cgrundey_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SHIFT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    work_t            work_q, work_d, work_step_c;
    logic [BIN_W-1:0] bin_q, bin_d;
    frame_t           frame_q, frame_d;
    logic             valid_q, valid_d;
    logic             rerr_q, rerr_d;
`ifdef TX_ERR_INJECT_EN
    logic             inj_q, inj_d;
`endif

    dabble_step_cgrundey u_step (
        .work        (work_q),
        .work_next_c (work_step_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            bin_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            rerr_q  <= 1'b0;
`ifdef TX_ERR_INJECT_EN
            inj_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            bin_q   <= bin_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            rerr_q  <= rerr_d;
`ifdef TX_ERR_INJECT_EN
            inj_q   <= inj_d;
`endif
        end
    end

    // Next-state and datapath; range_err is a single-cycle pulse by default.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        bin_d   = bin_q;
        frame_d = frame_q;
        valid_d = valid_q;
        rerr_d  = 1'b0;
`ifdef TX_ERR_INJECT_EN
        inj_d   = inj_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.data_valid) begin
                    if (in_range(bus.data_in)) begin
                        work_d.tens  = '0;
                        work_d.units = '0;
                        work_d.bin   = bus.data_in;
                        bin_d        = bus.data_in;
                        cnt_d        = '0;
                        state_d      = SHIFT;
`ifdef TX_ERR_INJECT_EN
                        inj_d        = bus.err_inject;
`endif
                    end else begin
                        rerr_d = 1'b1;
                    end
                end
            end

            SHIFT: begin
                work_d = work_step_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    frame_d.bin   = bin_q;
                    frame_d.tens  = work_step_c.tens[TENS_FRAME_W-1:0];
                    frame_d.units = work_step_c.units;
`ifdef TX_ERR_INJECT_EN
                    frame_d.bin[0] = bin_q[0] ^ inj_q;
`endif
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                if (bus.frame_ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.data_ready  = (state_q == IDLE);
    assign bus.frame_out   = frame_q;
    assign bus.frame_valid = valid_q;
    assign bus.range_err   = rerr_q;

endmodule

// File: tb/tb_transmit_cgrundey.sv
// Self-checking bench for transmit_cgrundey: vector table, hand sequences, randomized model check.
module tb_transmit_cgrundey;
    import transmit_cgrundey_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    transmit_cgrundey_if bus();

    transmit_cgrundey dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [11:0] last_frame = 12'h000;

    typedef struct {
        int          value;
        logic [11:0] exp_frame;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: frame = {value, decimal tens, decimal units}, optional bit-6 flip.
    function automatic logic [11:0] model(input int v, input bit inj);
        logic [11:0] f;
        f = {6'(v), 2'(v / 10), 4'(v % 10)};
        if (inj) f[6] = ~f[6];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Legal value: accept, expect valid 6 edges later, optionally stall before ack.
    task automatic run_frame(input int v, input logic [11:0] exp, input int ack_delay,
                             input bit poke_valid, input string tag);
        int lat;
        chk({tag, "/ready_idle"}, 32'(bus.data_ready), 1);
        bus.data_in    = 6'(v);
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        chk({tag, "/ready_busy"}, 32'(bus.data_ready), 0);
        lat = 0;
        while (!bus.frame_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 6);
        chk({tag, "/frame"}, 32'(bus.frame_out), 32'(exp));
        for (int i = 0; i < ack_delay; i++) begin
            if (poke_valid) begin
                bus.data_in    = 6'd7;
                bus.data_valid = 1'b1;
            end
            tick();
            chk({tag, "/hold_frame"}, 32'(bus.frame_out), 32'(exp));
            chk({tag, "/hold_valid"}, 32'(bus.frame_valid), 1);
            chk({tag, "/hold_ready"}, 32'(bus.data_ready), 0);
        end
        bus.data_valid = 1'b0;
        bus.frame_ack  = 1'b1;
        tick();
        bus.frame_ack  = 1'b0;
        chk({tag, "/valid_drop"}, 32'(bus.frame_valid), 0);
        chk({tag, "/ready_back"}, 32'(bus.data_ready), 1);
        last_frame = exp;
    endtask

    // Out-of-range value: one-cycle range_err, no frame, frame_out untouched.
    task automatic run_reject(input int v, input string tag);
        chk({tag, "/ready_idle"}, 32'(bus.data_ready), 1);
        bus.data_in    = 6'(v);
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        chk({tag, "/range_err"}, 32'(bus.range_err), 1);
        chk({tag, "/no_valid"}, 32'(bus.frame_valid), 0);
        chk({tag, "/still_ready"}, 32'(bus.data_ready), 1);
        chk({tag, "/frame_kept"}, 32'(bus.frame_out), 32'(last_frame));
        tick();
        chk({tag, "/err_clear"}, 32'(bus.range_err), 0);
        chk({tag, "/frame_kept2"}, 32'(bus.frame_out), 32'(last_frame));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.frame_ack  = 1'b0;
`ifdef TX_ERR_INJECT_EN
        bus.err_inject = 1'b0;
`endif

        vecs.push_back('{25, 12'h665, 1'b0});
        vecs.push_back('{39, 12'h9F9, 1'b0});
        vecs.push_back('{0,  12'h000, 1'b0});
        vecs.push_back('{40, 12'h000, 1'b1});
        vecs.push_back('{10, 12'h290, 1'b0});
        vecs.push_back('{63, 12'h000, 1'b1});
        vecs.push_back('{7,  12'h1C7, 1'b0});
        vecs.push_back('{38, 12'h9B8, 1'b0});
        vecs.push_back('{20, 12'h520, 1'b0});

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        chk("rst/frame_out", 32'(bus.frame_out), 0);
        chk("rst/frame_valid", 32'(bus.frame_valid), 0);
        chk("rst/data_ready", 32'(bus.data_ready), 1);
        chk("rst/range_err", 32'(bus.range_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].exp_err) run_reject(vecs[i].value, $sformatf("vec%0d", i));
            else run_frame(vecs[i].value, vecs[i].exp_frame, 1, 1'b0, $sformatf("vec%0d", i));
        end

        // Backpressure: 10 stalled cycles with new data offered
        run_frame(25, 12'h665, 10, 1'b1, "backpressure");
        tick();
        chk("backpressure/no_reaccept", 32'(bus.data_ready), 1);

        // Reset asserted during SHIFT iteration 3
        chk("midrst/ready_idle", 32'(bus.data_ready), 1);
        bus.data_in    = 6'd30;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst/frame_out", 32'(bus.frame_out), 0);
        chk("midrst/frame_valid", 32'(bus.frame_valid), 0);
        chk("midrst/data_ready", 32'(bus.data_ready), 1);
        chk("midrst/range_err", 32'(bus.range_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_frame = 12'h000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midrst/no_valid", 32'(bus.frame_valid), 0);
        end
        run_frame(25, 12'h665, 0, 1'b0, "after_rst");

`ifdef TX_ERR_INJECT_EN
        bus.err_inject = 1'b1;
        run_frame(25, 12'h625, 0, 1'b0, "inject_on");
        bus.err_inject = 1'b0;
        run_frame(25, 12'h665, 0, 1'b0, "inject_off");
`endif

        // Sweep of the legal range
        for (int v = 0; v <= 39; v++) begin
            run_frame(v, model(v, 1'b0), 0, 1'b0, $sformatf("sweep%0d", v));
        end

        // Randomized values, stalls and (when built in) error injection
        for (int i = 0; i < 40; i++) begin
            int v;
            int d;
            bit inj;
            v   = int'($urandom_range(63, 0));
            d   = int'($urandom_range(3, 0));
            inj = 1'b0;
`ifdef TX_ERR_INJECT_EN
            inj = 1'($urandom_range(1, 0));
            bus.err_inject = inj;
`endif
            if (v > 39) run_reject(v, $sformatf("rand%0d_v%0d", i, v));
            else run_frame(v, model(v, inj), d, 1'($urandom_range(1, 0)),
                           $sformatf("rand%0d_v%0d", i, v));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/transmit_cgrundey.md
# transmit_cgrundey

Transmit-side frame builder feeding the receive checker. Accepts a 6-bit binary value (0–39) over a valid/ready handshake. Converts it to 2-digit BCD iteratively with a 6-cycle shift-add-3 sequence. Presents a 12-bit frame {binary[5:0], bcd[5:0]} under a valid/ack handshake, so the receiver's BCD-to-binary conversion of frame[5:0] matches frame[11:6].

## Interface
- Parameters: none; all widths are fixed by the frame format.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  6  binary value to transmit, legal range 0–39
- data_valid  in  1  data_in is offered this cycle
- data_ready  out  1  block is able to accept; high only in IDLE
- frame_out  out  12  [11:6] = binary value, [5:4] = BCD tens, [3:0] = BCD units
- frame_valid  out  1  frame_out holds a complete frame
- frame_ack  in  1  downstream consumed frame_out this cycle
- range_err  out  1  one-cycle pulse: an accepted data_in exceeded 39
- err_inject  in  1  only present with TX_ERR_INJECT_EN

## Operation
- States:
  - IDLE: data_ready = 1.
  - SHIFT: 6 iterations, 3-bit counter 0..5.
  - HOLD: frame_valid = 1.
- Accept occurs on an edge where data_valid && data_ready.
  - data_in ≤ 39: latch it into the shift register and a binary copy, clear the BCD accumulators, go to SHIFT, counter = 0.
  - data_in > 39: stay in IDLE, pulse range_err for the following cycle, leave frame_out unchanged.
- SHIFT iteration, per cycle:
  - If units ≥ 5, add 3 to units.
  - Shift {tens[2:0], units[3:0], bin[5:0]} left by one.
  - Increment the counter.
  - After iteration 5, load frame_out ← {binary copy, tens[1:0], units}, go to HOLD.
- Accumulator widths:
  - Tens is 3 bits internally; bit 2 is always 0 for legal inputs and is dropped at the frame.
  - Units is 4 bits.
  - Adds never overflow in range.
- HOLD: frame_out and frame_valid are stable. On an edge with frame_ack = 1, go to IDLE and drop frame_valid.
- frame_ack is ignored outside HOLD.
- data_valid while not in IDLE: ignored; the upstream holds the value until data_ready.
- frame_out retains its last frame in IDLE and SHIFT; it is only meaningful while frame_valid = 1.

## Timing
- Reset values, applied asynchronously:
  - state = IDLE, counter = 0, frame_out = 12'h000
  - frame_valid = 0, range_err = 0, data_ready = 1
- data_ready is decoded combinationally from state, so it goes low in the cycle after the accept edge.
- Latency: accept on edge E0 → frame_valid rises on edge E6. Minimum cycle period from accept to accept is 8 edges (E0 accept, E6 valid, E7 ack, E8 next accept).
- No back-to-back overlap: a new accept cannot occur until the cycle after the ack edge.
- Reset asserted mid-SHIFT or mid-HOLD:
  - Aborts immediately.
  - The frame is lost, with no partial frame_valid.
  - Outputs take reset values.
- range_err is high exactly one cycle, the cycle after the rejecting edge, and does not block the next accept.

## Configuration
- TX_ERR_INJECT_EN defined:
  - Adds the err_inject port.
  - err_inject is sampled at accept; if it was 1, frame_out[6] is inverted when the frame is loaded.
  - The downstream check then fails for that frame. Used for receiver fault coverage.
- TX_ERR_INJECT_EN undefined:
  - The port is absent.
  - frame_out is always a correct frame.

## Structure
- Shared package holds:
  - the state enum (IDLE, SHIFT, HOLD)
  - constants: BIN_W = 6, FRAME_W = 12, MAX_VAL = 39, SHIFT_CYCLES = 6
- One sub-module: dabble_step_cgrundey, a combinational single iteration (add-3 correction plus one-bit left shift over the 13-bit working vector). It is instantiated once and driven by the SHIFT state register.

## Test plan
- Reset, then data_in = 25 with valid → frame_valid at E6, frame_out = 12'h665; ack → IDLE, data_ready = 1 next cycle.
- data_in = 39 → 12'h9F9; data_in = 0 → 12'h000; sweep 0..39 → frame[11:6] equals the BCD-decoded frame[5:0] for every value.
- data_in = 40 and 63 → range_err one-cycle pulse, frame_valid stays 0, frame_out unchanged, next legal value accepted normally.
- Backpressure: hold frame_ack = 0 for 10 cycles in HOLD → frame_out constant, frame_valid = 1, data_ready = 0, new data_valid ignored.
- Assert rst_n low at iteration 3 of SHIFT → outputs at reset values immediately, no frame_valid after release.
- With TX_ERR_INJECT_EN, data_in = 25 and err_inject = 1 → frame_out = 12'h625; with err_inject = 0 → 12'h665.
